// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and writeback request type
package rf_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback requesters, write port, scoreboard and hazard query bundle
interface rf_wb_arbiter_if;
  import rf_pkg::*;

  logic            req0_valid;
  logic            req0_ready;
  logic [AW-1:0]   req0_addr;
  logic [XLEN-1:0] req0_data;
  logic            req1_valid;
  logic            req1_ready;
  logic [AW-1:0]   req1_addr;
  logic [XLEN-1:0] req1_data;
  logic            wr_enable;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            sb_set;
  logic [AW-1:0]   sb_set_addr;
  logic [AW-1:0]   q_addr1;
  logic            q_busy1;
  logic [AW-1:0]   q_addr2;
  logic            q_busy2;
  logic [AW:0]     pending_count;
  logic            sb_err;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output sb_set, sb_set_addr, q_addr1, q_addr2,
    input  req0_ready, req1_ready, wr_enable, wr_addr, wr_data,
    input  q_busy1, q_busy2, pending_count, sb_err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  sb_set, sb_set_addr, q_addr1, q_addr2,
    output req0_ready, req1_ready, wr_enable, wr_addr, wr_data,
    output q_busy1, q_busy2, pending_count, sb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write scoreboard for long-latency destinations
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic [AW-1:0] set_addr,
  input  logic          clr,
  input  logic [AW-1:0] clr_addr,
  input  logic          wr_enable,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] q_addr1,
  output logic          q_busy1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_busy2,
  output logic [AW:0]   pending_count,
  output logic          sb_err
);
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     count_q;
  logic [AW:0]     count_nxt;
  logic            err_q;
  logic            set_ok;
  logic            err_hit;

  assign set_ok  = set && (set_addr != '0);
  assign err_hit = set_ok && pending[set_addr] && !(clr && (clr_addr == set_addr));

  // Set is applied after clear so a reissue in the retiring cycle stays outstanding.
  always_comb begin
    pend_nxt = pending;
    if (clr)
      pend_nxt[clr_addr] = 1'b0;
    if (set_ok)
      pend_nxt[set_addr] = 1'b1;
    count_nxt = '0;
    for (int i = 0; i < NREG; i++)
      count_nxt = count_nxt + {{AW{1'b0}}, pend_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pending <= pend_nxt;
      count_q <= count_nxt;
      if (err_hit)
        err_q <= 1'b1;
    end
  end

  // The in-flight write term covers the cycle between clear and the real RF write.
  assign q_busy1 = !rst && (q_addr1 != '0) &&
                   (pending[q_addr1] || (wr_enable && (wr_addr == q_addr1)));
  assign q_busy2 = !rst && (q_addr2 != '0) &&
                   (pending[q_addr2] || (wr_enable && (wr_addr == q_addr2)));

  assign pending_count = rst ? '0 : count_q;
  assign sb_err        = !rst && err_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin arbiter owning the register file write port
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);
  wb_req_t         r0;
  wb_req_t         r1;
  wb_req_t         win;
  logic            rr;
  logic            grant0;
  logic            grant1;
  logic            fire;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [XLEN-1:0] wr_data_q;

  assign r0 = {bus.req0_valid, bus.req0_addr, bus.req0_data};
  assign r1 = {bus.req1_valid, bus.req1_addr, bus.req1_data};

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (r0.valid && (!r1.valid || !rr))
        grant0 = 1'b1;
      else if (r1.valid)
        grant1 = 1'b1;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign fire           = grant0 || grant1;
  assign win            = grant0 ? r0 : r1;

  always_ff @(posedge clk) begin
    if (rst)
      rr <= 1'b0;
    else if (grant0)
      rr <= 1'b1;
    else if (grant1)
      rr <= 1'b0;
  end

  // x0 writes are acknowledged but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (fire && (win.addr != '0)) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= win.addr;
      wr_data_q <= win.data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  // Gating with rst drops a write that was registered just before reset.
  assign bus.wr_enable = wr_en_q && !rst;
  assign bus.wr_addr   = rst ? '0 : wr_addr_q;
  assign bus.wr_data   = rst ? '0 : wr_data_q;

  rf_scoreboard u_sb (
    .clk           (clk),
    .rst           (rst),
    .set           (bus.sb_set),
    .set_addr      (bus.sb_set_addr),
    .clr           (grant1),
    .clr_addr      (r1.addr),
    .wr_enable     (bus.wr_enable),
    .wr_addr       (bus.wr_addr),
    .q_addr1       (bus.q_addr1),
    .q_busy1       (bus.q_busy1),
    .q_addr2       (bus.q_addr2),
    .q_busy2       (bus.q_busy2),
    .pending_count (bus.pending_count),
    .sb_err        (bus.sb_err)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed table and randomized model check of rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  a0;
    logic [63:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [63:0] d1;
    logic        ss;
    logic [4:0]  sa;
    logic [4:0]  q1;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic        e_busy;
    logic [5:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                     input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                     input logic ss, input logic [4:0] sa, input logic [4:0] q1,
                     input logic er0, input logic er1, input logic ewe, input logic [4:0] ewa,
                     input logic [63:0] ewd, input logic ebusy, input logic [5:0] ecnt,
                     input logic eerr);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.ss = ss; v.sa = sa; v.q1 = q1; v.e_r0 = er0; v.e_r1 = er1; v.e_we = ewe;
    v.e_wa = ewa; v.e_wd = ewd; v.e_busy = ebusy; v.e_cnt = ecnt; v.e_err = eerr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                       input logic ss, input logic [4:0] sa, input logic [4:0] q1,
                       input logic [4:0] q2);
    rst = r;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.sb_set = ss; bus.sb_set_addr = sa;
    bus.q_addr1 = q1; bus.q_addr2 = q2;
  endtask

  // Reference state: what the spec says is visible after the most recent edge.
  int          m_turn;
  bit          m_pend[32];
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic bit m_busy(input logic r, input logic [4:0] q);
    if (r || q == 5'd0) return 1'b0;
    return m_pend[q] || (m_we && m_wa == q);
  endfunction

  logic        hv0, hv1, rr_ss, rr_r;
  logic [4:0]  ha0, ha1, rr_sa, rq1, rq2;
  logic [63:0] hd0, hd1;
  bit          e0, e1;

  initial begin
    tests = 0;
    fails = 0;
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   rst v0 a0 d0      v1 a1 d1      ss sa  q1   r0 r1 we wa  wd      busy cnt err
    add(1, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  0,   0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(1, 1, 5, 64'hAA, 0, 0, 64'h0,  0, 0,  0,   0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  7,   0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 1, 5, 64'hAA, 0, 0, 64'h0,  0, 0,  5,   1, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  5,   0, 0, 1, 5,  64'hAA, 1, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  5,   0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(1, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  0,   0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 1, 3, 64'h11, 1, 4, 64'h22, 0, 0,  0,   1, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 1, 3, 64'h11, 1, 4, 64'h22, 0, 0,  0,   0, 1, 1, 3,  64'h11, 0, 0, 0);
    add(0, 1, 3, 64'h11, 1, 4, 64'h22, 0, 0,  0,   1, 0, 1, 4,  64'h22, 0, 0, 0);
    add(0, 1, 3, 64'h11, 1, 4, 64'h22, 0, 0,  0,   0, 1, 1, 3,  64'h11, 0, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  0,   0, 0, 1, 4,  64'h22, 0, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  1, 7,  7,   0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  7,   0, 0, 0, 0,  64'h0,  1, 1, 0);
    add(0, 0, 0, 64'h0,  1, 7, 64'h33, 0, 0,  7,   0, 1, 0, 0,  64'h0,  1, 1, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  7,   0, 0, 1, 7,  64'h33, 1, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  7,   0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  1, 9,  9,   0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 0, 0, 64'h0,  1, 9, 64'h44, 1, 9,  9,   0, 1, 0, 0,  64'h0,  1, 1, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  9,   0, 0, 1, 9,  64'h44, 1, 1, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  1, 9,  9,   0, 0, 0, 0,  64'h0,  1, 1, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  9,   0, 0, 0, 0,  64'h0,  1, 1, 1);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  9,   0, 0, 0, 0,  64'h0,  1, 1, 1);
    add(0, 1, 0, 64'hFF, 0, 0, 64'h0,  0, 0,  0,   1, 0, 0, 0,  64'h0,  0, 1, 1);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  0,   0, 0, 0, 0,  64'h0,  0, 1, 1);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  1, 12, 12,  0, 0, 0, 0,  64'h0,  0, 1, 1);
    add(0, 0, 0, 64'h0,  1, 12, 64'h55, 0, 0, 12,  0, 1, 0, 0,  64'h0,  1, 2, 1);
    add(1, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  12,  0, 0, 0, 0,  64'h0,  0, 0, 0);
    add(0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  12,  0, 0, 0, 0,  64'h0,  0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1,
            vecs[i].d1, vecs[i].ss, vecs[i].sa, vecs[i].q1, 5'd0);
      #1;
      chk($sformatf("v%0d req0_ready", i), 64'(bus.req0_ready), 64'(vecs[i].e_r0));
      chk($sformatf("v%0d req1_ready", i), 64'(bus.req1_ready), 64'(vecs[i].e_r1));
      chk($sformatf("v%0d wr_enable", i), 64'(bus.wr_enable), 64'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d wr_addr", i), 64'(bus.wr_addr), 64'(vecs[i].e_wa));
        chk($sformatf("v%0d wr_data", i), bus.wr_data, vecs[i].e_wd);
      end
      chk($sformatf("v%0d q_busy1", i), 64'(bus.q_busy1), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d pending_count", i), 64'(bus.pending_count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d sb_err", i), 64'(bus.sb_err), 64'(vecs[i].e_err));
    end

    for (int a = 0; a < 32; a++) begin
      bus.q_addr1 = 5'(a);
      bus.q_addr2 = 5'(31 - a);
      #1;
      chk($sformatf("idle q_busy1[%0d]", a), 64'(bus.q_busy1), 64'd0);
      chk($sformatf("idle q_busy2[%0d]", 31 - a), 64'(bus.q_busy2), 64'd0);
    end

    hv0 = 1'b0; hv1 = 1'b0;
    ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
    m_turn = 0; m_err = 0; m_we = 0; m_wa = '0; m_wd = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rr_r = (c == 0) || ($urandom_range(0, 99) == 0);
      if (!hv0 && $urandom_range(0, 1) == 1) begin
        hv0 = 1'b1; ha0 = 5'($urandom_range(0, 31)); hd0 = {$urandom, $urandom};
      end
      if (!hv1 && $urandom_range(0, 1) == 1) begin
        hv1 = 1'b1; ha1 = 5'($urandom_range(0, 31)); hd1 = {$urandom, $urandom};
      end
      rr_ss = ($urandom_range(0, 3) == 0);
      rr_sa = 5'($urandom_range(0, 31));
      rq1   = 5'($urandom_range(0, 31));
      rq2   = 5'($urandom_range(0, 31));
      drive(rr_r, hv0, ha0, hd0, hv1, ha1, hd1, rr_ss, rr_sa, rq1, rq2);
      #1;

      e0 = !rr_r && hv0 && (!hv1 || m_turn == 0);
      e1 = !rr_r && hv1 && (!hv0 || m_turn == 1);
      chk("rnd req0_ready", 64'(bus.req0_ready), 64'(e0));
      chk("rnd req1_ready", 64'(bus.req1_ready), 64'(e1));
      chk("rnd wr_enable", 64'(bus.wr_enable), 64'(!rr_r && m_we));
      if (!rr_r && m_we) begin
        chk("rnd wr_addr", 64'(bus.wr_addr), 64'(m_wa));
        chk("rnd wr_data", bus.wr_data, m_wd);
      end
      chk("rnd q_busy1", 64'(bus.q_busy1), 64'(m_busy(rr_r, rq1)));
      chk("rnd q_busy2", 64'(bus.q_busy2), 64'(m_busy(rr_r, rq2)));
      chk("rnd pending_count", 64'(bus.pending_count), rr_r ? 64'd0 : 64'(m_count()));
      chk("rnd sb_err", 64'(bus.sb_err), 64'(!rr_r && m_err));

      if (rr_r) begin
        m_turn = 0; m_err = 0; m_we = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
        m_we = 1'b0;
        if (e0 || e1) begin
          m_turn = e0 ? 1 : 0;
          if ((e0 ? ha0 : ha1) != 5'd0) begin
            m_we = 1'b1;
            m_wa = e0 ? ha0 : ha1;
            m_wd = e0 ? hd0 : hd1;
          end
        end
        if (rr_ss && rr_sa != 5'd0 && m_pend[rr_sa] && !(e1 && ha1 == rr_sa))
          m_err = 1'b1;
        if (e1) m_pend[ha1] = 1'b0;
        if (rr_ss && rr_sa != 5'd0) m_pend[rr_sa] = 1'b1;
      end
      if (e0) hv0 = 1'b0;
      if (e1) hv1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
